keypad_scanner: RTL and testbench

Synchronous 4x4 matrix-keypad front end for the calculator datapath. It drives the rows one-hot, samples the columns through a synchroniser, and debounces each press. Every clean press is decoded into one key event (digit value or operator code) according to the BASE mode, and the event is handed downstream over a valid/ready handshake with overrun detection. It sits between the keypad pins and the calculator control FSM.

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/keypad_keymap.sv | 51 +++++
 rtl/keypad_scanner.sv | 180 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix-keypad front end.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  // Operator codes handed to the calculator control FSM
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_EQ   = 3'd4;

  // Scanner states: free-running scan, confirming a press, waiting for release
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } scan_state_t;

  // True when exactly one column line is active
  function automatic logic is_single(input logic [KP_COLS-1:0] v);
    return ($countones(v) == 1);
  endfunction

  // Index of the highest active column line (only meaningful for a single bit)
  function automatic logic [1:0] col_index(input logic [KP_COLS-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < KP_COLS; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_keymap.sv
// Key position {row, col} to calculator event decode for the selected base.
// Latency: purely combinational.
// Backpressure: none; valid=0 for an unsupported base so nothing is emitted.
module keypad_keymap
  import keypad_pkg::*;
#(
  parameter int BASE = 10
) (
  input  logic [1:0] row,
  input  logic [1:0] col,
  output logic [3:0] value,
  output logic [2:0] op,
  output logic       is_digit,
  output logic       valid
);

  // Table lookup; calculator layout rows are "1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D"
  always_comb begin
    value    = '0;
    op       = OP_NONE;
    is_digit = 1'b0;
    valid    = 1'b0;
    if (BASE == 16) begin
      value    = {row, col};
      is_digit = 1'b1;
      valid    = 1'b1;
    end else if (BASE == 10) begin
      valid    = 1'b1;
      is_digit = 1'b1;
      case ({row, col})
        4'd0:    value = 4'd1;
        4'd1:    value = 4'd2;
        4'd2:    value = 4'd3;
        4'd3:    begin op = OP_ADD; is_digit = 1'b0; end
        4'd4:    value = 4'd4;
        4'd5:    value = 4'd5;
        4'd6:    value = 4'd6;
        4'd7:    begin op = OP_SUB; is_digit = 1'b0; end
        4'd8:    value = 4'd7;
        4'd9:    value = 4'd8;
        4'd10:   value = 4'd9;
        4'd11:   value = 4'd12;
        4'd12:   value = 4'd14;
        4'd13:   value = 4'd0;
        4'd14:   begin op = OP_EQ; is_digit = 1'b0; end
        default: value = 4'd13;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scan, debounce and decode into a one-deep valid/ready event register.
// Latency: event valid on the edge after the DEBOUNCE-th matching dwell sample.
// Backpressure: an event arriving while one is pending and unaccepted is dropped; overrun latches.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  parameter int BASE     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KP_COLS-1:0] col_sense,
  output logic [KP_ROWS-1:0] row_drive,
  output logic               key_valid,
  input  logic               key_ready,
  output logic [3:0]         key_value,
  output logic [2:0]         key_op,
  output logic               key_is_digit,
  output logic               overrun,
  input  logic               overrun_clr
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE);

  logic [KP_COLS-1:0] sync1, sync2;
  logic [DW-1:0]      dwell_cnt;
  logic               sample_tick;

  scan_state_t        state, state_nxt;
  logic [1:0]         row_idx, row_nxt;
  logic [KP_COLS-1:0] cap_col, cap_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               emit;

  logic [3:0]         map_value;
  logic [2:0]         map_op;
  logic               map_digit;
  logic               map_valid;

  // Two-flop synchroniser for the asynchronous column lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= col_sense;
      sync2 <= sync1;
    end
  end

  // Dwell counter; the last clock of each dwell is the sample point
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
    end else if (sample_tick) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  assign sample_tick = (dwell_cnt == DWELL_LAST);
  assign row_drive   = KP_ROWS'(1) << row_idx;

  // Emission only happens with the key's row driven and its single column sampled,
  // so the live row and sampled column address the decoder directly.
  keypad_keymap #(.BASE(BASE)) u_keymap (
    .row      (row_idx),
    .col      (col_index(sync2)),
    .value    (map_value),
    .op       (map_op),
    .is_digit (map_digit),
    .valid    (map_valid)
  );

  // Scan FSM state, current row, captured column and match/release count
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_SCAN;
      row_idx <= '0;
      cap_col <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      row_idx <= row_nxt;
      cap_col <= cap_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Next-state decisions, evaluated only on the dwell sample clock
  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    cap_nxt   = cap_col;
    cnt_nxt   = cnt;
    emit      = 1'b0;
    if (sample_tick) begin
      case (state)
        ST_SCAN: begin
          if (is_single(sync2)) begin
            cap_nxt = sync2;
            if (CNT_TARGET == CW'(1)) begin
              emit      = map_valid;
              state_nxt = ST_HELD;
              cnt_nxt   = '0;
            end else begin
              state_nxt = ST_DEBOUNCE;
              cnt_nxt   = CW'(1);
            end
          end else begin
            row_nxt = row_idx + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (sync2 == cap_col) begin
            if (cnt + CW'(1) == CNT_TARGET) begin
              emit      = map_valid;
              state_nxt = ST_HELD;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end else begin
            state_nxt = ST_SCAN;
            row_nxt   = row_idx + 2'd1;
            cnt_nxt   = '0;
          end
        end
        ST_HELD: begin
          if (sync2 == '0) begin
            if (cnt + CW'(1) == CNT_TARGET) begin
              state_nxt = ST_SCAN;
              row_nxt   = row_idx + 2'd1;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt = ST_SCAN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // One-deep event register with sticky overrun; an accept frees the slot for a same-cycle load
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid    <= 1'b0;
      key_value    <= '0;
      key_op       <= OP_NONE;
      key_is_digit <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (emit && (!key_valid || key_ready)) begin
        key_valid    <= 1'b1;
        key_value    <= map_value;
        key_op       <= map_op;
        key_is_digit <= map_digit;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      if (emit && key_valid && !key_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives two instances (calculator and hex maps).
// Expected events come from a layout-table reference and queue scoreboards.
// Timing-exact scenarios count edges from the last reset edge.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam logic [13:0] RST_OBS = {4'b0001, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        key_ready = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [15:0] press_a = '0;
  logic [15:0] press_b = '0;

  logic [3:0] col_a, col_b, row_a, row_b, val_a, val_b;
  logic [2:0] op_a, op_b;
  logic       kv_a, kv_b, dig_a, dig_b, ovr_a, ovr_b;
  logic [13:0] obs_a, obs_b;

  int checks = 0;
  int fails  = 0;
  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB), .BASE(10)) dut_a (
    .clk(clk), .rst(rst), .col_sense(col_a), .row_drive(row_a),
    .key_valid(kv_a), .key_ready(key_ready), .key_value(val_a), .key_op(op_a),
    .key_is_digit(dig_a), .overrun(ovr_a), .overrun_clr(overrun_clr)
  );

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB), .BASE(16)) dut_b (
    .clk(clk), .rst(rst), .col_sense(col_b), .row_drive(row_b),
    .key_valid(kv_b), .key_ready(key_ready), .key_value(val_b), .key_op(op_b),
    .key_is_digit(dig_b), .overrun(ovr_b), .overrun_clr(overrun_clr)
  );

  assign obs_a = {row_a, kv_a, val_a, op_a, dig_a, ovr_a};
  assign obs_b = {row_b, kv_b, val_b, op_b, dig_b, ovr_b};

  // Physical matrix: a pressed key shorts its row line onto its column line
  always_comb begin
    col_a = '0;
    col_b = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (row_a[r] === 1'b1 && press_a[r*4+c]) col_a[c] = 1'b1;
        if (row_b[r] === 1'b1 && press_b[r*4+c]) col_b[c] = 1'b1;
      end
    end
  end

  // Record every handshake completed on the following edge
  always @(negedge clk) begin
    if (rst === 1'b0 && key_ready === 1'b1) begin
      if (kv_a === 1'b1) rx_a.push_back({val_a, op_a, dig_a});
      if (kv_b === 1'b1) rx_b.push_back({val_b, op_b, dig_b});
    end
  end

  // Reference decode straight from the printed key layout: {value, op, is_digit}
  function automatic logic [7:0] model_key(input int base, input int row, input int col);
    string layout;
    byte   ch;
    logic [7:0] ev;
    layout = "123A456B789C*0#D";
    if (base == 16) return {4'(row * 4 + col), OP_NONE, 1'b1};
    ch = layout[row * 4 + col];
    ev = 8'hFF;
    if (ch >= "0" && ch <= "9") ev = {4'(ch - "0"), OP_NONE, 1'b1};
    else if (ch == "A") ev = {4'd0, OP_ADD, 1'b0};
    else if (ch == "B") ev = {4'd0, OP_SUB, 1'b0};
    else if (ch == "#") ev = {4'd0, OP_EQ, 1'b0};
    else if (ch == "C") ev = {4'd12, OP_NONE, 1'b1};
    else if (ch == "*") ev = {4'd14, OP_NONE, 1'b1};
    else if (ch == "D") ev = {4'd13, OP_NONE, 1'b1};
    return ev;
  endfunction

  function automatic logic [15:0] kbit(input int row, input int col);
    return 16'(1) << (row * 4 + col);
  endfunction

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_dwells(input int n);
    wait_edges(n * SD);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      key_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic flush();
    rx_a.delete();
    rx_b.delete();
  endtask

  task automatic test_reset();
    logic [3:0] er;
    press_a = '0; press_b = '0; key_ready = 1'b0; overrun_clr = 1'b0;
    do_reset();
    checks++; if (obs_a !== RST_OBS) begin fails++; $display("FAIL reset_a: got %h want %h", obs_a, RST_OBS); end
    checks++; if (obs_b !== RST_OBS) begin fails++; $display("FAIL reset_b: got %h want %h", obs_b, RST_OBS); end
    wait_edges(3);
    checks++; if (row_a !== 4'b0001) begin fails++; $display("FAIL row_hold: got %b want 0001", row_a); end
    for (int i = 1; i <= 4; i++) begin
      wait_edges(1);
      er = 4'b0001 << (i % 4);
      checks++; if (row_a !== er) begin fails++; $display("FAIL row_rotate%0d: got %b want %b", i, row_a, er); end
      wait_edges(3);
    end
  endtask

  task automatic test_latency_and_reset_held();
    logic [7:0] e1;
    e1 = model_key(10, 0, 0);
    flush(); key_ready = 1'b0; press_a = kbit(0, 0);
    do_reset();
    wait_edges(11);
    checks++; if (kv_a !== 1'b0) begin fails++; $display("FAIL lat_early: got %b want 0", kv_a); end
    wait_edges(1);
    checks++; if ({kv_a, val_a, op_a, dig_a} !== {1'b1, e1}) begin fails++; $display("FAIL lat_event: got %h want %h", {kv_a, val_a, op_a, dig_a}, {1'b1, e1}); end
    wait_dwells(3);
    checks++; if ({kv_a, ovr_a} !== 2'b10) begin fails++; $display("FAIL held_norepeat: got %b want 10", {kv_a, ovr_a}); end
    pulse_reset();
    checks++; if (obs_a !== RST_OBS) begin fails++; $display("FAIL held_reset: got %h want %h", obs_a, RST_OBS); end
    wait_edges(11);
    checks++; if (kv_a !== 1'b0) begin fails++; $display("FAIL fresh_early: got %b want 0", kv_a); end
    wait_edges(1);
    checks++; if ({kv_a, val_a, op_a, dig_a} !== {1'b1, e1}) begin fails++; $display("FAIL fresh_event: got %h want %h", {kv_a, val_a, op_a, dig_a}, {1'b1, e1}); end
    key_ready = 1'b1; wait_edges(1); key_ready = 1'b0;
    checks++; if (rx_a.size() !== 1) begin fails++; $display("FAIL fresh_count: got %0d want 1", rx_a.size()); end
    checks++; if (kv_a !== 1'b0) begin fails++; $display("FAIL fresh_accept: got %b want 0", kv_a); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] e1, e4, got;
    e1 = model_key(10, 0, 0);
    e4 = model_key(10, 1, 0);
    flush(); key_ready = 1'b0; press_a = kbit(0, 0);
    do_reset();
    wait_edges(12);
    press_a = kbit(1, 0);
    wait_edges(23);
    checks++; if ({kv_a, val_a} !== {1'b1, 4'd1}) begin fails++; $display("FAIL sim_pending: got %h want 11", {kv_a, val_a}); end
    key_ready = 1'b1; wait_edges(1); key_ready = 1'b0;
    checks++; if ({kv_a, val_a, op_a, dig_a} !== {1'b1, e4}) begin fails++; $display("FAIL sim_load: got %h want %h", {kv_a, val_a, op_a, dig_a}, {1'b1, e4}); end
    checks++; if (ovr_a !== 1'b0) begin fails++; $display("FAIL sim_overrun: got %b want 0", ovr_a); end
    got = (rx_a.size() > 0) ? rx_a[0] : 8'hFF;
    checks++; if (got !== e1 || rx_a.size() != 1) begin fails++; $display("FAIL sim_accepted: got %h (n=%0d) want %h", got, rx_a.size(), e1); end
    key_ready = 1'b1; wait_edges(1); key_ready = 1'b0;
    press_a = '0; wait_dwells(8);
  endtask

  task automatic test_hold();
    logic [7:0] e6, got;
    e6 = model_key(10, 1, 2);
    flush(); key_ready = 1'b1;
    press_a = kbit(1, 2); wait_dwells(20);
    got = (rx_a.size() > 0) ? rx_a[0] : 8'hFF;
    checks++; if (rx_a.size() !== 1) begin fails++; $display("FAIL hold_count: got %0d want 1", rx_a.size()); end
    checks++; if (got !== e6) begin fails++; $display("FAIL hold_value: got %h want %h", got, e6); end
    press_a = '0; wait_dwells(1); press_a = kbit(1, 2); wait_dwells(10);
    checks++; if (rx_a.size() !== 1) begin fails++; $display("FAIL hold_short_release: got %0d want 1", rx_a.size()); end
    press_a = '0; wait_dwells(8); press_a = kbit(1, 2); wait_dwells(12);
    got = (rx_a.size() > 1) ? rx_a[1] : 8'hFF;
    checks++; if (rx_a.size() !== 2) begin fails++; $display("FAIL hold_second: got %0d want 2", rx_a.size()); end
    checks++; if (got !== e6) begin fails++; $display("FAIL hold_second_value: got %h want %h", got, e6); end
    press_a = '0; wait_dwells(8);
  endtask

  task automatic test_bounce();
    logic [7:0] eh, got;
    eh = model_key(10, 3, 2);
    flush(); key_ready = 1'b1;
    press_a = kbit(3, 2); wait_dwells(1);
    press_a = '0; wait_dwells(1);
    checks++; if (rx_a.size() !== 0) begin fails++; $display("FAIL bounce_quiet: got %0d want 0", rx_a.size()); end
    press_a = kbit(3, 2); wait_dwells(16);
    got = (rx_a.size() > 0) ? rx_a[0] : 8'hFF;
    checks++; if (rx_a.size() !== 1 || got !== eh) begin fails++; $display("FAIL bounce_event: got %h (n=%0d) want %h", got, rx_a.size(), eh); end
    press_a = '0; wait_dwells(8);
  endtask

  task automatic test_overrun();
    logic [7:0] e5, got;
    e5 = model_key(10, 1, 1);
    flush(); key_ready = 1'b0;
    press_a = kbit(1, 1); wait_dwells(16); press_a = '0; wait_dwells(8);
    press_a = kbit(2, 1); wait_dwells(16); press_a = '0; wait_dwells(8);
    checks++; if ({kv_a, val_a, op_a, dig_a, ovr_a} !== {1'b1, e5, 1'b1}) begin fails++; $display("FAIL overrun_set: got %h want %h", {kv_a, val_a, op_a, dig_a, ovr_a}, {1'b1, e5, 1'b1}); end
    overrun_clr = 1'b1; wait_edges(1); overrun_clr = 1'b0;
    checks++; if ({kv_a, val_a, ovr_a} !== {1'b1, 4'd5, 1'b0}) begin fails++; $display("FAIL overrun_clr: got %h want %h", {kv_a, val_a, ovr_a}, {1'b1, 4'd5, 1'b0}); end
    key_ready = 1'b1; wait_edges(1); key_ready = 1'b0;
    got = (rx_a.size() > 0) ? rx_a[0] : 8'hFF;
    checks++; if (rx_a.size() !== 1 || got !== e5) begin fails++; $display("FAIL overrun_kept: got %h (n=%0d) want %h", got, rx_a.size(), e5); end
    checks++; if (kv_a !== 1'b0) begin fails++; $display("FAIL overrun_drain: got %b want 0", kv_a); end
  endtask

  task automatic test_multikey_base16();
    logic [7:0] eb, got;
    eb = model_key(16, 2, 3);
    flush(); key_ready = 1'b1;
    press_a = kbit(1, 0) | kbit(1, 3);
    press_b = kbit(2, 0) | kbit(2, 1);
    wait_dwells(16);
    checks++; if (rx_a.size() !== 0) begin fails++; $display("FAIL multikey_a: got %0d want 0", rx_a.size()); end
    checks++; if (rx_b.size() !== 0) begin fails++; $display("FAIL multikey_b: got %0d want 0", rx_b.size()); end
    press_a = '0; press_b = '0; wait_dwells(8);
    press_b = kbit(2, 3); wait_dwells(16);
    got = (rx_b.size() > 0) ? rx_b[0] : 8'hFF;
    checks++; if (rx_b.size() !== 1 || got !== eb) begin fails++; $display("FAIL hex_key: got %h (n=%0d) want %h", got, rx_b.size(), eb); end
    press_b = '0; wait_dwells(8);
  endtask

  task automatic test_random();
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] got;
    flush();
    for (int it = 0; it < 10; it++) begin
      int ra, ca, ca2, rb, cb;
      ra = int'($urandom_range(0, 3)); ca = int'($urandom_range(0, 3));
      rb = int'($urandom_range(0, 3)); cb = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        ca2 = (ca + 1 + int'($urandom_range(0, 2))) % 4;
        press_a = kbit(ra, ca) | kbit(ra, ca2);
      end else begin
        press_a = kbit(ra, ca);
        exp_a.push_back(model_key(10, ra, ca));
      end
      press_b = kbit(rb, cb);
      exp_b.push_back(model_key(16, rb, cb));
      rand_cycles(16 * SD);
      press_a = '0; press_b = '0;
      rand_cycles(8 * SD);
    end
    key_ready = 1'b1; wait_edges(4); key_ready = 1'b0;
    checks++; if (rx_a.size() !== exp_a.size()) begin fails++; $display("FAIL rand_count_a: got %0d want %0d", rx_a.size(), exp_a.size()); end
    checks++; if (rx_b.size() !== exp_b.size()) begin fails++; $display("FAIL rand_count_b: got %0d want %0d", rx_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      got = (i < rx_a.size()) ? rx_a[i] : 8'hFF;
      checks++; if (got !== exp_a[i]) begin fails++; $display("FAIL rand_a[%0d]: got %h want %h", i, got, exp_a[i]); end
    end
    for (int i = 0; i < exp_b.size(); i++) begin
      got = (i < rx_b.size()) ? rx_b[i] : 8'hFF;
      checks++; if (got !== exp_b[i]) begin fails++; $display("FAIL rand_b[%0d]: got %h want %h", i, got, exp_b[i]); end
    end
    checks++; if ({ovr_a, ovr_b} !== 2'b00) begin fails++; $display("FAIL rand_overrun: got %b want 00", {ovr_a, ovr_b}); end
  endtask

  initial begin
    test_reset();
    test_latency_and_reset_held();
    test_simultaneous();
    test_hold();
    test_bounce();
    test_overrun();
    test_multikey_base16();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
